// File: rtl/alu_pkg.sv
// Shared ALU definitions: op codes, data width and response-register state encoding.
package alu_pkg;

    localparam int DATA_W = 32;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_OR  = 3'b010;
    localparam logic [2:0] ALU_LUI = 3'b011;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } rsp_state_e;

endpackage

// File: rtl/alu_core.sv
// Combinational 32-bit ALU: add, sub, or, and B<<16 for every other op code.
// Latency: none. Backpressure: none.
module alu_core
    import alu_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [2:0]        op,
    output logic [DATA_W-1:0] out,
    output logic              zero
);

    always_comb begin
        out = '0;
        case (op)
            ALU_ADD: out = a + b;
            ALU_SUB: out = a - b;
            ALU_OR:  out = a | b;
            default: out = b << 16;
        endcase
    end

    // Equality is taken on the operands, not on the result.
    assign zero = (a == b);

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin shares one ALU among NUM_REQ valid/ready requesters; ALU_ARB_STATS_EN adds grant counters.
// Latency: result registered, visible one cycle after accept; one result per cycle when drained.
// Backpressure: a full, undrained response register drops every req_ready and freezes the pointer.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] req_a,
    input  logic [NUM_REQ*DATA_W-1:0] req_b,
    input  logic [NUM_REQ*3-1:0]      req_op,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [ID_W-1:0]           rsp_id,
    output logic [DATA_W-1:0]         rsp_out,
    output logic                      rsp_zero
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [NUM_REQ*16-1:0]     grant_cnt
`endif
);

    rsp_state_e        state_q, state_d;
    logic [ID_W-1:0]   ptr_q, ptr_nxt;
    logic [ID_W-1:0]   gnt;
    logic              found;
    logic              drain, can_accept, accept;
    logic [DATA_W-1:0] a_sel, b_sel, alu_out;
    logic [2:0]        op_sel;
    logic              alu_zero;
    int                idx;

    // Winner search uses only valids and the pointer, so operands never reach ready.
    always_comb begin
        found = 1'b0;
        gnt   = '0;
        idx   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(ptr_q) + k) % NUM_REQ;
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                gnt   = ID_W'(idx);
            end
        end
    end

    assign drain      = rsp_valid & rsp_ready;
    assign can_accept = (state_q == EMPTY) | drain;
    assign accept     = reset & can_accept & found;

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = accept & (gnt == ID_W'(i));
        end
    end

    assign ptr_nxt = (int'(gnt) == NUM_REQ - 1) ? '0 : gnt + 1'b1;

    assign a_sel  = req_a[DATA_W*int'(gnt) +: DATA_W];
    assign b_sel  = req_b[DATA_W*int'(gnt) +: DATA_W];
    assign op_sel = req_op[3*int'(gnt) +: 3];

    alu_core u_alu_core (
        .a    (a_sel),
        .b    (b_sel),
        .op   (op_sel),
        .out  (alu_out),
        .zero (alu_zero)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: if (accept) state_d = FULL;
            FULL:  if (drain && !accept) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= EMPTY;
            ptr_q    <= '0;
            rsp_id   <= '0;
            rsp_out  <= '0;
            rsp_zero <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                ptr_q    <= ptr_nxt;
                rsp_id   <= gnt;
                rsp_out  <= alu_out;
                rsp_zero <= alu_zero;
            end
        end
    end

    assign rsp_valid = (state_q == FULL);

`ifdef ALU_ARB_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            grant_cnt <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_ready[i] && grant_cnt[i*16 +: 16] != 16'hFFFF)
                    grant_cnt[i*16 +: 16] <= grant_cnt[i*16 +: 16] + 16'd1;
            end
        end
    end
`endif

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares one ALU between `NUM_REQ` requesters (e.g. the execute stage and a multi-cycle helper unit) through valid/ready request channels. It grants one request per cycle by round-robin and evaluates it through a single ALU instance. The result is returned on one registered response channel tagged with the requester index. The block sits between the requesters and the ALU, and owns all sequencing and backpressure for it.

## Interface
- `NUM_REQ`, default 2: number of requesters; legal range 2..4.
- `ID_W`, default 2: width of the requester index; must satisfy 2^ID_W >= NUM_REQ.

- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset. This is already decided and fixed.
- `req_valid` in NUM_REQ: per-requester request valid.
- `req_ready` out NUM_REQ: per-requester accept. At most one bit is high per cycle.
- `req_a` in NUM_REQ*32: operand A; requester i occupies bits [32i+31:32i].
- `req_b` in NUM_REQ*32: operand B, same packing as `req_a`.
- `req_op` in NUM_REQ*3: op code; requester i occupies bits [3i+2:3i].
- `rsp_valid` out 1: response register holds a result.
- `rsp_ready` in 1: consumer accepts the response.
- `rsp_id` out ID_W: index of the requester that produced the result.
- `rsp_out` out 32: ALU result.
- `rsp_zero` out 1: set when A == B, compared on the operands.

## Operation
- Op encoding:
  - 000: A+B
  - 001: A−B
  - 010: A|B
  - any other value: B<<16
- All arithmetic is 32-bit modulo. There are no overflow or trap outputs.
- Output register FSM:
  - EMPTY → FULL on accept.
  - FULL → FULL on drain plus accept in the same cycle.
  - FULL → EMPTY on drain with no accept.
- Definitions:
  - drain = `rsp_valid & rsp_ready`.
  - can_accept = EMPTY | drain.
- Grant:
  - Search starts at round-robin pointer `ptr` and moves upward modulo NUM_REQ.
  - The first requester with `req_valid` set wins.
  - `req_ready[g]` = can_accept & `req_valid[g]` for the winner g. All other ready bits are 0.
- Accept (valid & ready for the winner):
  - The ALU result, `rsp_zero`, and g load into the response register.
  - `ptr` becomes (g+1) mod NUM_REQ.
  - With no accept, `ptr` holds its value.
- Requester obligation: once `req_valid` is raised, it stays high with stable A, B and op until `req_ready` is seen.
- Consumer visibility: `rsp_out`, `rsp_zero` and `rsp_id` stay stable while `rsp_valid` is high and `rsp_ready` is low.
- Bubbles: a requester with `req_valid` low is skipped without a bubble cycle.

## Timing
- Reset values (asynchronous, applied immediately on assertion):
  - `rsp_valid` 0, `rsp_id` 0, `rsp_out` 0, `rsp_zero` 0.
  - `ptr` 0, state EMPTY.
  - `req_ready` is 0 while reset is asserted.
- Reset mid-operation: any held result is discarded and never delivered.
- Latency: a request accepted at edge N has `rsp_valid` high after edge N.
- Throughput: one result per cycle while `rsp_ready` stays high.
- Backpressure: FULL with `rsp_ready` low forces every `req_ready` to 0. Requesters stall and `ptr` freezes.
- Simultaneous events:
  - Drain and accept in the same cycle replace the register contents, and `rsp_valid` stays 1.
  - All requesters valid every cycle yields the strict rotation 0,1,…,NUM_REQ−1,0.
- `ptr` wrap-around: after a grant to NUM_REQ−1, the next search starts at 0.
- `req_ready` is combinational from `req_valid`, `ptr`, state and `rsp_ready`. There is no combinational path from `req_a`, `req_b` or `req_op` to any ready signal.

## Configuration
- Macro `ALU_ARB_STATS_EN`:
  - Defined: adds output `grant_cnt` (NUM_REQ*16). Each counter increments on its requester's accept and saturates at 0xFFFF. All counters reset to 0.
  - Undefined: the port and the counters do not exist, and behaviour is otherwise identical.

## Structure
- Shared package `alu_pkg`:
  - Op-code constants: `ALU_ADD`=3'b000, `ALU_SUB`=3'b001, `ALU_OR`=3'b010, `ALU_LUI`=3'b011.
  - Data width constant 32.
  - Response-state encoding EMPTY/FULL.
- Sub-module `alu_core`: purely combinational ALU (A, B, op → out, zero), instantiated once. The arbiter contains no arithmetic of its own.

## Test plan
- Single request:
  - Stimulus: req0 with A=5, B=3, op=001, `rsp_ready`=1.
  - Response: next cycle `rsp_valid`=1, `rsp_out`=2, `rsp_zero`=0, `rsp_id`=0.
- Both requesters valid for 4 cycles with `rsp_ready`=1:
  - Accept order is 0,1,0,1.
  - Results: req1 with A=0xFFFFFFFF, B=1, op=000 returns 0. req0 with A=7, B=7, op=010 returns 7 with `rsp_zero`=1.
- Backpressure:
  - Stimulus: `rsp_ready`=0 for 3 cycles with both requesters valid.
  - Response: exactly one accept. `req_ready` is 0 afterwards, the response is held stable, and on release the next grant goes to the other requester.
- LUI and default op:
  - op=011 with B=0x1234 returns 0x12340000.
  - op=111 with B=0x0001 returns 0x00010000.
- Reset while FULL with `rsp_ready`=0:
  - `rsp_valid` drops to 0 immediately.
  - After release, the first grant goes to req0 even if `ptr` was 1 before reset.
- With `ALU_ARB_STATS_EN` and NUM_REQ=2:
  - 70000 back-to-back req0 accepts give `grant_cnt[15:0]`=0xFFFF, saturated.
  - `grant_cnt[31:16]` stays 0.
